// File: rtl/nd_loop_sequencer.sv
// Registered N-dimensional loop sequencer: latches one loop-nest descriptor and
// emits one beat (indices, addresses, address sum, wrap flags) per accepted handshake.
module nd_loop_sequencer #(
   parameter int unsigned BW       = 16,
   parameter int unsigned DIM      = 4,
   parameter int unsigned SHAMT_BW = 3,
   localparam int unsigned SBW     = (SHAMT_BW > 0) ? SHAMT_BW : 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_cfg_rdy,
   output logic                     o_cfg_ack,
   input  logic [DIM-1:0][BW-1:0]   i_bound,
   input  logic [DIM-1:0][BW-1:0]   i_start,
   input  logic [DIM-1:0][BW-1:0]   i_step,
   input  logic [DIM-1:0][SBW-1:0]  i_shamt,
   output logic                     o_dst_rdy,
   input  logic                     i_dst_ack,
   output logic [DIM-1:0][BW-1:0]   o_idx,
   output logic [DIM-1:0][BW-1:0]   o_addr,
   output logic [BW-1:0]            o_addr_sum,
   output logic [DIM-1:0]           o_wrap,
   output logic                     o_last,
   output logic                     o_busy
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t                   state, state_next;
   logic [DIM-1:0][BW-1:0]   bound_q, start_q, inc_q;
   logic [DIM-1:0][BW-1:0]   bound_n, start_n, inc_n, idx_n, addr_n;
   logic [BW-1:0]            sum_n;
   logic [DIM-1:0]           wrap_n;
   logic                     rdy_n;
   logic                     carry;
   logic                     any_zero;

   // Dim d wraps when it and every inner dim sit at their last index.
   function automatic logic [DIM-1:0] calc_wrap(input logic [DIM-1:0][BW-1:0] idx,
                                                input logic [DIM-1:0][BW-1:0] bnd);
      logic           inner_last;
      logic [DIM-1:0] w;
      inner_last = 1'b1;
      w          = '0;
      for (int d = int'(DIM) - 1; d >= 0; d--) begin
         w[d]       = inner_last && (idx[d] == bnd[d] - BW'(1));
         inner_last = w[d];
      end
      return w;
   endfunction

   // Modulo-2^BW sum of all per-dim addresses.
   function automatic logic [BW-1:0] calc_sum(input logic [DIM-1:0][BW-1:0] a);
      logic [BW-1:0] s;
      s = '0;
      for (int d = 0; d < int'(DIM); d++) s = s + a[d];
      return s;
   endfunction

   // Empty-nest detection on the incoming descriptor.
   always_comb begin
      any_zero = 1'b0;
      for (int d = 0; d < int'(DIM); d++) if (i_bound[d] == '0) any_zero = 1'b1;
   end

   // Next-state, descriptor latch and odometer-style index/address advance.
   always_comb begin
      state_next = state;
      bound_n    = bound_q;
      start_n    = start_q;
      inc_n      = inc_q;
      idx_n      = o_idx;
      addr_n     = o_addr;
      rdy_n      = o_dst_rdy;
      carry      = 1'b1;
      unique case (state)
         IDLE: begin
            // Zero-trip descriptors are consumed and dropped without touching beat state.
            if (i_cfg_rdy && !any_zero) begin
               state_next = RUN;
               bound_n    = i_bound;
               start_n    = i_start;
               for (int d = 0; d < int'(DIM); d++) inc_n[d] = i_step[d] << i_shamt[d];
               idx_n      = '0;
               addr_n     = i_start;
               rdy_n      = 1'b1;
            end
         end
         RUN: begin
            if (i_dst_ack) begin
               if (o_last) begin
                  state_next = IDLE;
                  rdy_n      = 1'b0;
               end else begin
                  for (int d = int'(DIM) - 1; d >= 0; d--) begin
                     if (carry) begin
                        if (o_idx[d] == bound_q[d] - BW'(1)) begin
                           idx_n[d]  = '0;
                           addr_n[d] = start_q[d];
                        end else begin
                           idx_n[d]  = o_idx[d] + BW'(1);
                           addr_n[d] = o_addr[d] + inc_q[d];
                           carry     = 1'b0;
                        end
                     end
                  end
               end
            end
         end
      endcase
      wrap_n = calc_wrap(idx_n, bound_n);
      sum_n  = calc_sum(addr_n);
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (!i_rst) state <= IDLE;
      else        state <= state_next;
   end

   // Descriptor and beat output registers.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         bound_q    <= '0;
         start_q    <= '0;
         inc_q      <= '0;
         o_idx      <= '0;
         o_addr     <= '0;
         o_addr_sum <= '0;
         o_wrap     <= '0;
         o_last     <= 1'b0;
         o_dst_rdy  <= 1'b0;
         o_cfg_ack  <= 1'b1;
         o_busy     <= 1'b0;
      end else begin
         bound_q    <= bound_n;
         start_q    <= start_n;
         inc_q      <= inc_n;
         o_idx      <= idx_n;
         o_addr     <= addr_n;
         o_addr_sum <= sum_n;
         o_wrap     <= wrap_n;
         o_last     <= wrap_n[0];
         o_dst_rdy  <= rdy_n;
         o_cfg_ack  <= (state_next == IDLE);
         o_busy     <= (state_next != IDLE);
      end
   end

endmodule

// File: tb/tb_nd_loop_sequencer.sv
// Testbench for nd_loop_sequencer: directed nest table, hand sequences and random nests
// checked beat-by-beat against an enumerating reference model.
module tb_nd_loop_sequencer;

   typedef struct packed {
      logic [3:0][15:0] bound;
      logic [3:0][15:0] start;
      logic [3:0][15:0] step;
      logic [3:0][2:0]  shamt;
   } desc_t;

   typedef struct packed {
      logic [3:0][15:0] idx;
      logic [3:0][15:0] addr;
      logic [15:0]      sum;
      logic [3:0]       wrap;
      logic             last;
   } beat_t;

   typedef struct {
      desc_t       d;
      int          beats;
      logic [15:0] first_sum;
      logic [15:0] last_sum;
   } vec_t;

   logic             i_clk = 1'b0;
   logic             i_rst;
   logic             i_cfg_rdy;
   logic             o_cfg_ack;
   logic [3:0][15:0] i_bound, i_start, i_step;
   logic [3:0][2:0]  i_shamt;
   logic             o_dst_rdy;
   logic             i_dst_ack;
   logic [3:0][15:0] o_idx, o_addr;
   logic [15:0]      o_addr_sum;
   logic [3:0]       o_wrap;
   logic             o_last;
   logic             o_busy;

   int          n_checks = 0;
   int          n_errors = 0;
   beat_t       exp_q[$];
   logic [15:0] seen_sums[$];
   logic [3:0]  last_wrap;
   vec_t        vecs[6];

   nd_loop_sequencer #(.BW(16), .DIM(4), .SHAMT_BW(3)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_cfg_rdy(i_cfg_rdy), .o_cfg_ack(o_cfg_ack),
      .i_bound(i_bound), .i_start(i_start), .i_step(i_step), .i_shamt(i_shamt),
      .o_dst_rdy(o_dst_rdy), .i_dst_ack(i_dst_ack), .o_idx(o_idx), .o_addr(o_addr),
      .o_addr_sum(o_addr_sum), .o_wrap(o_wrap), .o_last(o_last), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Enumerate the nest as a mixed-radix count; dim 3 is the least significant digit.
   function automatic void build_model(input desc_t d);
      int    total, rem;
      int    bi[4];
      beat_t b;
      exp_q.delete();
      total = 1;
      for (int k = 0; k < 4; k++) total *= int'(d.bound[k]);
      for (int n = 0; n < total; n++) begin
         rem = n;
         for (int k = 3; k >= 0; k--) begin
            bi[k] = rem % int'(d.bound[k]);
            rem   = rem / int'(d.bound[k]);
         end
         b.sum = '0;
         for (int k = 0; k < 4; k++) begin
            b.idx[k]  = 16'(bi[k]);
            b.addr[k] = 16'(int'(d.start[k]) + bi[k] * (int'(d.step[k]) << d.shamt[k]));
            b.sum     = 16'(b.sum + b.addr[k]);
         end
         for (int k = 0; k < 4; k++) begin
            b.wrap[k] = 1'b1;
            for (int e = k; e < 4; e++) if (bi[e] != int'(d.bound[e]) - 1) b.wrap[k] = 1'b0;
         end
         b.last = (n == total - 1);
         exp_q.push_back(b);
      end
   endfunction

   task automatic drive_desc(input desc_t d);
      i_bound = d.bound;
      i_start = d.start;
      i_step  = d.step;
      i_shamt = d.shamt;
   endtask

   // Hand one descriptor to the DUT and consume its beats with random backpressure.
   task automatic run_nest(input desc_t d, input int ack_pct);
      int   cycles;
      logic acked;
      build_model(d);
      seen_sums.delete();
      check("idle_cfg_ack", 64'(o_cfg_ack), 64'd1);
      drive_desc(d);
      i_cfg_rdy = 1'b1;
      i_dst_ack = 1'($urandom_range(1));
      @(negedge i_clk);
      i_cfg_rdy = 1'b0;
      i_bound   = {$urandom(), $urandom()};
      i_start   = {$urandom(), $urandom()};
      i_step    = {$urandom(), $urandom()};
      i_shamt   = 12'($urandom());
      if (exp_q.size() == 0) begin
         for (int c = 0; c < 3; c++) begin
            check("empty_dst_rdy", 64'(o_dst_rdy), 64'd0);
            check("empty_busy", 64'(o_busy), 64'd0);
            check("empty_cfg_ack", 64'(o_cfg_ack), 64'd1);
            @(negedge i_clk);
         end
         i_dst_ack = 1'b0;
         return;
      end
      cycles = 0;
      while (exp_q.size() > 0 && cycles < 1000) begin
         check("dst_rdy", 64'(o_dst_rdy), 64'd1);
         check("busy", 64'(o_busy), 64'd1);
         check("cfg_ack_run", 64'(o_cfg_ack), 64'd0);
         check("idx", 64'(o_idx), 64'(exp_q[0].idx));
         check("addr", 64'(o_addr), 64'(exp_q[0].addr));
         check("addr_sum", 64'(o_addr_sum), 64'(exp_q[0].sum));
         check("wrap", 64'(o_wrap), 64'(exp_q[0].wrap));
         check("last", 64'(o_last), 64'(exp_q[0].last));
         acked     = ($urandom_range(99) < ack_pct);
         i_dst_ack = acked;
         if (o_dst_rdy && acked) begin
            seen_sums.push_back(o_addr_sum);
            last_wrap = o_wrap;
            void'(exp_q.pop_front());
         end
         @(negedge i_clk);
         cycles++;
      end
      check("beats_left_at_timeout", 64'(exp_q.size()), 64'd0);
      i_dst_ack = 1'b1;
      check("done_dst_rdy", 64'(o_dst_rdy), 64'd0);
      check("done_busy", 64'(o_busy), 64'd0);
      check("done_cfg_ack", 64'(o_cfg_ack), 64'd1);
      @(negedge i_clk);
      check("done_stray_ack", 64'(o_dst_rdy), 64'd0);
      i_dst_ack = 1'b0;
   endtask

   initial begin
      logic [15:0] t1_sums[6];
      desc_t       rd;

      // Directed nests (packed concat order is {dim3, dim2, dim1, dim0}; dim 3 innermost).
      vecs[0] = '{d: '{bound: {16'd3, 16'd2, 16'd1, 16'd1}, start: {16'd10, 16'd100, 16'd0, 16'd0},
                       step: {16'd1, 16'd20, 16'd0, 16'd0}, shamt: '0},
                  beats: 6, first_sum: 16'd110, last_sum: 16'd132};
      vecs[1] = '{d: '{bound: {16'd0, 16'd3, 16'd1, 16'd1}, start: '0, step: '0, shamt: '0},
                  beats: 0, first_sum: 16'd0, last_sum: 16'd0};
      vecs[2] = '{d: '{bound: {16'd1, 16'd1, 16'd1, 16'd1}, start: {16'd11, 16'd9, 16'd7, 16'd5},
                       step: {16'd3, 16'd3, 16'd3, 16'd3}, shamt: '0},
                  beats: 1, first_sum: 16'd32, last_sum: 16'd32};
      vecs[3] = '{d: '{bound: {16'd4, 16'd1, 16'd1, 16'd1}, start: {16'd65530, 16'd0, 16'd0, 16'd0},
                       step: {16'd2, 16'd0, 16'd0, 16'd0}, shamt: {3'd1, 3'd0, 3'd0, 3'd0}},
                  beats: 4, first_sum: 16'd65530, last_sum: 16'd6};
      vecs[4] = '{d: '{bound: {16'd2, 16'd2, 16'd2, 16'd2}, start: {16'd4, 16'd3, 16'd2, 16'd1},
                       step: {16'd1, 16'd1, 16'd1, 16'd1}, shamt: '0},
                  beats: 16, first_sum: 16'd10, last_sum: 16'd14};
      vecs[5] = '{d: '{bound: {16'd3, 16'd1, 16'd1, 16'd1}, start: '0,
                       step: {16'd3, 16'd0, 16'd0, 16'd0}, shamt: {3'd2, 3'd0, 3'd0, 3'd0}},
                  beats: 3, first_sum: 16'd0, last_sum: 16'd24};
      t1_sums = '{16'd110, 16'd111, 16'd112, 16'd130, 16'd131, 16'd132};

      i_rst     = 1'b0;
      i_cfg_rdy = 1'b0;
      i_dst_ack = 1'b0;
      drive_desc('0);
      last_wrap = '0;
      repeat (2) @(negedge i_clk);
      check("rst_cfg_ack", 64'(o_cfg_ack), 64'd1);
      check("rst_dst_rdy", 64'(o_dst_rdy), 64'd0);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_idx", 64'(o_idx), 64'd0);
      check("rst_addr", 64'(o_addr), 64'd0);
      check("rst_sum", 64'(o_addr_sum), 64'd0);
      check("rst_wrap", 64'(o_wrap), 64'd0);
      check("rst_last", 64'(o_last), 64'd0);
      i_rst = 1'b1;
      @(negedge i_clk);

      // Directed table, alternating full-rate and throttled acceptance.
      for (int i = 0; i < 6; i++) begin
         run_nest(vecs[i].d, (i % 2 == 0) ? 100 : 40);
         check($sformatf("vec%0d_beats", i), 64'(seen_sums.size()), 64'(vecs[i].beats));
         if (vecs[i].beats > 0 && seen_sums.size() > 0) begin
            check($sformatf("vec%0d_first_sum", i), 64'(seen_sums[0]), 64'(vecs[i].first_sum));
            check($sformatf("vec%0d_last_sum", i), 64'(seen_sums[seen_sums.size()-1]),
                  64'(vecs[i].last_sum));
            check($sformatf("vec%0d_last_wrap", i), 64'(last_wrap), 64'hF);
         end
      end

      // Test-1 nest under sparse acceptance yields the exact same beat sequence.
      run_nest(vecs[0].d, 35);
      check("bp_beats", 64'(seen_sums.size()), 64'd6);
      for (int i = 0; i < 6; i++)
         if (i < seen_sums.size()) check($sformatf("bp_sum%0d", i), 64'(seen_sums[i]), 64'(t1_sums[i]));

      // Reset after beat 2 abandons the nest; a new descriptor restarts from idx 0.
      drive_desc(vecs[0].d);
      i_cfg_rdy = 1'b1;
      i_dst_ack = 1'b1;
      @(negedge i_clk);
      i_cfg_rdy = 1'b0;
      check("mid_beat1_sum", 64'(o_addr_sum), 64'd110);
      @(negedge i_clk);
      check("mid_beat2_sum", 64'(o_addr_sum), 64'd111);
      i_rst = 1'b0;
      @(negedge i_clk);
      check("mid_rst_dst_rdy", 64'(o_dst_rdy), 64'd0);
      check("mid_rst_busy", 64'(o_busy), 64'd0);
      check("mid_rst_cfg_ack", 64'(o_cfg_ack), 64'd1);
      check("mid_rst_idx", 64'(o_idx), 64'd0);
      i_rst = 1'b1;
      @(negedge i_clk);
      check("mid_rst_no_beat", 64'(o_dst_rdy), 64'd0);
      i_dst_ack = 1'b0;
      run_nest(vecs[0].d, 100);
      check("restart_beats", 64'(seen_sums.size()), 64'd6);
      if (seen_sums.size() > 0) check("restart_first_sum", 64'(seen_sums[0]), 64'd110);

      // Random nests with random backpressure against the reference model.
      for (int r = 0; r < 40; r++) begin
         for (int k = 0; k < 4; k++) begin
            rd.bound[k] = ($urandom_range(9) == 0) ? 16'd0 : 16'($urandom_range(1, 3));
            rd.start[k] = 16'($urandom());
            rd.step[k]  = 16'($urandom());
            rd.shamt[k] = 3'($urandom());
         end
         run_nest(rd, int'($urandom_range(30, 100)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
